// File: rtl/dram_cache_pkg.sv
// ============================================================================
// Module  : dram_cache_pkg
// Brief   : Shared types and helpers for the DRAM-cache request path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dram_cache_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_HOLD = 1'b1} arb_state_t;

  function automatic int src_w(input int n);
    return $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/req_queue_sched_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Rotating priority encoder; first set request at or after i_ptr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import dram_cache_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = src_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_any = 1'b1;
        o_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/req_queue_sched.sv
// ============================================================================
// Module  : req_queue_sched
// Brief   : Round-robin drain of NUM_REQ request FIFOs into one registered
//           valid/ready port. Define ARB_BURST_EN for per-source burst hold.
// Revision: 1.0
// ============================================================================
`default_nettype none

module req_queue_sched
  import dram_cache_pkg::*;
#(
  parameter int   NUM_REQ       = 4,
  parameter int   DATA_BIT_SIZE = 64,
  parameter int   MAX_BURST     = 4,
  localparam int  SRC_W         = src_w(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               q_empty,
  input  logic [NUM_REQ*DATA_BIT_SIZE-1:0] q_read_data,
  output logic [NUM_REQ-1:0]               q_read_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_BIT_SIZE-1:0]         out_data,
  output logic [SRC_W-1:0]                 out_src,
  output logic                             busy
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_cfg_err
    $error("req_queue_sched: parameter out of range");
  end

  function automatic logic [SRC_W-1:0] f_inc(input logic [SRC_W-1:0] x);
    return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
  endfunction

  logic [DATA_BIT_SIZE-1:0] w_heads [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_heads
    assign w_heads[gi] = q_read_data[gi*DATA_BIT_SIZE +: DATA_BIT_SIZE];
  end

  logic                     r_out_valid;
  logic [DATA_BIT_SIZE-1:0] r_out_data;
  logic [SRC_W-1:0]         r_out_src;
  logic [SRC_W-1:0]         r_rr_ptr;
  logic [SRC_W-1:0]         w_pick_ptr;
  logic [SRC_W-1:0]         w_pick_idx;
  logic                     w_pick_any;
  logic [SRC_W-1:0]         w_sel;
  logic                     w_slot_free;
  logic                     w_load;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req (~q_empty),
    .i_ptr (w_pick_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Gating with rst_n keeps upstream FIFOs untouched while reset is held.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_load      = rst_n && w_slot_free && w_pick_any;

`ifdef ARB_BURST_EN
  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

  arb_state_t       r_state, w_state_nxt;
  logic [SRC_W-1:0] r_cur, w_cur_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [SRC_W-1:0] w_rr_ptr_nxt;
  logic             w_hold_exit;
  logic             w_keep;

  // Leaving HOLD re-arbitrates in the same cycle starting after the holder.
  assign w_hold_exit = (r_state == ARB_HOLD) && w_slot_free &&
                       (q_empty[r_cur] || (r_cnt == c_max_burst));
  assign w_keep      = (r_state == ARB_HOLD) && !w_hold_exit;
  assign w_pick_ptr  = (r_state == ARB_HOLD) ? f_inc(r_cur) : r_rr_ptr;
  assign w_sel       = w_keep ? r_cur : w_pick_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ARB_IDLE;
      r_cur    <= '0;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cur    <= w_cur_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cur_nxt    = r_cur;
    w_cnt_nxt    = r_cnt;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_keep) begin
      if (w_load) w_cnt_nxt = r_cnt + 4'd1;
    end else begin
      if (w_hold_exit) begin
        w_state_nxt  = ARB_IDLE;
        w_rr_ptr_nxt = f_inc(r_cur);
      end
      if (w_load) begin
        w_rr_ptr_nxt = f_inc(w_sel);
        if (MAX_BURST > 1) begin
          w_state_nxt = ARB_HOLD;
          w_cur_nxt   = w_sel;
          w_cnt_nxt   = 4'd1;
        end
      end
    end
  end
`else
  assign w_pick_ptr = r_rr_ptr;
  assign w_sel      = w_pick_idx;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_rr_ptr <= '0;
    else if (w_load) r_rr_ptr <= f_inc(w_sel);
  end
`endif

  always_comb begin
    q_read_en = '0;
    if (w_load) q_read_en[w_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_heads[w_sel];
      r_out_src   <= w_sel;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign busy      = r_out_valid || (|(~q_empty));

endmodule

`default_nettype wire

// File: tb/tb_req_queue_sched.sv
// ============================================================================
// Module  : tb_req_queue_sched
// Brief   : Directed + random bench for req_queue_sched with queue-based FIFOs
//           and a grant-order reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_req_queue_sched;

  localparam int N  = 4;
  localparam int D  = 64;
  localparam int MB = 4;
`ifdef ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     q_empty;
  logic [N*D-1:0]   q_read_data;
  logic [N-1:0]     q_read_en;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [D-1:0]     out_data;
  logic [1:0]       out_src;
  logic             busy;

  always #5 clk = ~clk;

  req_queue_sched #(.NUM_REQ(N), .DATA_BIT_SIZE(D), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .q_empty     (q_empty),
    .q_read_data (q_read_data),
    .q_read_en   (q_read_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_src     (out_src),
    .busy        (busy)
  );

  logic [D-1:0] fifo [N][$];
  int checks = 0;
  int errors = 0;

  // Reference model: output slot plus grant bookkeeping
  bit           m_valid = 0;
  logic [D-1:0] m_data  = '0;
  int           m_src = 0, m_ptr = 0, m_cur = 0, m_cnt = 0;
  bit           m_hold = 0;
  bit           e_load;
  int           e_sel, n_ptr, n_cur, n_cnt;
  bit           n_hold;

  bit rec = 0;
  int got_src[$];
  int exp_src[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void update_views();
    for (int i = 0; i < N; i++) begin
      q_empty[i] = (fifo[i].size() == 0);
      q_read_data[i*D +: D] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endfunction

  function automatic bit any_ne();
    for (int i = 0; i < N; i++) if (fifo[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int rr_first(input int p);
    for (int k = 0; k < N; k++) if (fifo[(p + k) % N].size() != 0) return (p + k) % N;
    return -1;
  endfunction

  function automatic void model_eval();
    bit slot_free, holding;
    int ptr;
    slot_free = !m_valid || out_ready;
    holding   = m_hold;
    ptr       = m_ptr;
    if (holding && slot_free && (fifo[m_cur].size() == 0 || m_cnt >= MB)) begin
      holding = 0;
      ptr     = (m_cur + 1) % N;
    end
    if (holding) e_sel = (fifo[m_cur].size() != 0) ? m_cur : -1;
    else         e_sel = rr_first(ptr);
    e_load = rst_n && slot_free && (e_sel >= 0);
    n_ptr = ptr; n_hold = holding; n_cur = m_cur; n_cnt = m_cnt;
    if (e_load) begin
      if (holding) n_cnt++;
      else begin
        n_ptr = (e_sel + 1) % N;
        if (BURST && MB > 1) begin n_hold = 1; n_cur = e_sel; n_cnt = 1; end
      end
    end
  endfunction

  task automatic cycle();
    update_views();
    #1;
    model_eval();
    chk("q_read_en", q_read_en, e_load ? (64'd1 << e_sel) : 64'd0);
    chk("busy", busy, m_valid || any_ne());
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0; m_hold = 0; m_cur = 0; m_cnt = 0;
    end else begin
      if (e_load) begin
        m_data  = fifo[e_sel].pop_front();
        m_src   = e_sel;
        m_valid = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
      m_ptr = n_ptr; m_hold = n_hold; m_cur = n_cur; m_cnt = n_cnt;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_src", out_src, m_src);
    if (rec && out_valid) got_src.push_back(int'(out_src));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic collect(input int n);
    got_src.delete();
    rec = 1;
    run(n);
    rec = 0;
    chk("seq_len", got_src.size(), exp_src.size());
    for (int i = 0; i < got_src.size() && i < exp_src.size(); i++)
      chk("seq_src", got_src[i], exp_src[i]);
  endtask

  task automatic push(input int q, input int cnt);
    repeat (cnt) fifo[q].push_back({$urandom, $urandom});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) fifo[i].delete();
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [D-1:0] held;
    // Reset with every FIFO non-empty: no pops, empty output slot
    for (int i = 0; i < N; i++) push(i, 1);
    update_views();
    @(negedge clk);
    run(2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    update_views();
    #1;
    chk("first_grant", q_read_en, 64'd1);
    run(7);

    // Round robin, three entries each, back-to-back
    do_reset();
    for (int i = 0; i < N; i++) push(i, 3);
`ifdef ARB_BURST_EN
    exp_src = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
`else
    exp_src = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`endif
    collect(13);

    // Backpressure: output frozen, no pops
    push(1, 2);
    push(2, 1);
    out_ready = 1'b0;
    cycle();
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_hold", out_data, held);
    end
    out_ready = 1'b1;
    run(5);

    // Wrap and skip with the pointer parked at 2
    do_reset();
    push(1, 1);
    run(3);
    push(1, 1);
    push(3, 2);
`ifdef ARB_BURST_EN
    exp_src = '{3, 3, 1};
`else
    exp_src = '{3, 1, 3};
`endif
    collect(5);

    // Uneven depths: burst hold and switch on empty
    do_reset();
    push(0, 6);
    push(2, 2);
`ifdef ARB_BURST_EN
    exp_src = '{0, 0, 0, 0, 2, 2, 0, 0};
`else
    exp_src = '{0, 2, 0, 2, 0, 0, 0, 0};
`endif
    collect(10);

    // Random traffic and backpressure
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++)
        if (fifo[i].size() < 6 && $urandom_range(0, 3) == 0) push(i, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    out_ready = 1'b1;
    run(30);

    // Reset while an entry is stalled in the output register
    do_reset();
    push(1, 2);
    push(3, 1);
    out_ready = 1'b0;
    cycle();
    chk("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) fifo[i].delete();
    cycle();
    chk("reset_clears_valid", out_valid, 1'b0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    push(2, 1);
    push(0, 1);
    exp_src = '{0, 2};
    collect(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/req_queue_sched.md
# req_queue_sched

Round-robin scheduler that drains NUM_REQ per-requester request FIFOs into one shared DRAM-cache request port. It sits between the requester-side FIFOs (show-ahead head data, pop on read_en) and the cache controller's valid/ready command input. It pops at most one FIFO per cycle and registers the popped entry together with its source ID.

## Interface
Parameters:
- NUM_REQ, 4, number of requester FIFOs (2..16)
- DATA_BIT_SIZE, 64, request payload width
- MAX_BURST, 4, maximum consecutive pops from one FIFO while ARB_BURST_EN is set (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- q_empty  in  NUM_REQ  per-FIFO empty flag
- q_read_data  in  NUM_REQ*DATA_BIT_SIZE  flattened head data; FIFO i occupies bits [i*DATA_BIT_SIZE +: DATA_BIT_SIZE]
- q_read_en  out  NUM_REQ  per-FIFO pop strobe; combinational; at most one bit set
- out_valid  out  1  output register holds a request
- out_ready  in  1  downstream accepts in the current cycle
- out_data  out  DATA_BIT_SIZE  registered payload
- out_src  out  $clog2(NUM_REQ)  index of the source FIFO of out_data
- busy  out  1  out_valid OR any q_empty bit low

## Operation
- load = (!out_valid | out_ready) & (|~q_empty). On load, q_read_en[sel] = 1, and out_data/out_src capture q_read_data[sel]/sel on the next edge.
- When no load occurs, q_read_en is all zero.
- A stall (out_valid & !out_ready) holds out_data/out_src stable and drives no pops.
- Fairness: sel is the first non-empty FIFO at or after rr_ptr, searching upward modulo NUM_REQ. After a grant in IDLE state, rr_ptr = sel+1, wrapping NUM_REQ-1 -> 0.
- State machine (only with ARB_BURST_EN; otherwise stays in IDLE):
  - IDLE: round-robin select. On load with MAX_BURST>1, go to HOLD with cur=sel and burst_cnt=1.
  - HOLD: sel=cur while q_empty[cur]=0. Each load increments burst_cnt.
  - HOLD exits to IDLE when burst_cnt reaches MAX_BURST, or when q_empty[cur]=1 at a cycle where load would otherwise occur. On exit, rr_ptr=cur+1 and the same cycle performs a round-robin select, so there is no bubble.
  - A stall in HOLD keeps the state and burst_cnt unchanged.
- busy is combinational from the current out_valid and q_empty.

## Timing
- Reset values: out_valid 0, out_data 0, out_src 0, q_read_en 0, rr_ptr 0, state IDLE, burst_cnt 0.
- Latency: a non-empty head with the slot free at cycle t gives out_valid=1 at t+1.
- Throughput: one request per cycle when out_ready is held high.
- Simultaneous accept and load: the old entry leaves and the new entry is captured on the same edge, so out_valid stays 1.
- q_read_en must not depend on out_data, to avoid a combinational loop. It may depend on out_ready.
- Reset mid-operation: the output register is cleared and any entry popped but not accepted is discarded. Upstream FIFOs share rst_n.
- When all FIFOs are empty and the slot is free: out_valid=0 on the next edge, and rr_ptr/state are unchanged (IDLE) or return to IDLE (HOLD).

## Configuration
- ARB_BURST_EN defined: the HOLD state and burst_cnt are present, and a source keeps the grant for up to MAX_BURST consecutive pops.
- ARB_BURST_EN undefined: pure per-pop round-robin, no HOLD state, MAX_BURST ignored.

## Structure
- Package dram_cache_pkg:
  - typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t
  - function src_w(n) returning $clog2(n)
- Sub-module rr_pick: combinational rotating priority encoder. Inputs are a request vector and rr_ptr. Outputs are the grant index and any-grant. It is reused by other arbiters in the cache.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all FIFOs non-empty -> out_valid=0, q_read_en=0. First grant after reset goes to FIFO 0.
- Round-robin, ARB_BURST_EN off: all 4 FIFOs hold 3 entries, out_ready=1 -> out_src sequence 0,1,2,3,0,1,2,3,0,1,2,3 and 12 back-to-back valids.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> out_data/out_src constant and q_read_en=0 throughout. Release -> the next entry appears one cycle later.
- Wrap and skip: only FIFOs 1 and 3 non-empty, rr_ptr=2 -> grant 3, then 1, then 3.
- Burst, ARB_BURST_EN on, MAX_BURST=4: FIFO0 holds 6 entries, FIFO2 holds 2 -> out_src 0,0,0,0,2,2,0,0. FIFO0 going empty mid-burst -> immediate switch with no idle cycle.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 on the next edge and state returns to IDLE.
